// File: rtl/online_sd_pkg.sv
// Shared definitions for the radix-2 online signed-digit datapath:
// digit encodings, digit<->integer helpers, online delay and frame states.
package online_sd_pkg;

  localparam int DELTA = 3;

  localparam logic [1:0] SD_POS  = 2'b01;
  localparam logic [1:0] SD_ZERO = 2'b00;
  localparam logic [1:0] SD_NEG  = 2'b11;

  typedef enum logic [1:0] {LOAD, RUN, FLUSH} state_t;

  // 2'b10 is not a legal digit and decodes as zero.
  function automatic logic signed [1:0] sd_to_int(input logic [1:0] d);
    if (d == SD_POS)      return 2'sd1;
    else if (d == SD_NEG) return -2'sd1;
    else                  return 2'sd0;
  endfunction

  function automatic logic [1:0] int_to_sd(input logic signed [1:0] v);
    if (v == 2'sd1)       return SD_POS;
    else if (v == -2'sd1) return SD_NEG;
    else                  return SD_ZERO;
  endfunction

endpackage

// File: rtl/sd_digit_select.sv
// Radix-2 online digit selection on a truncated residual estimate
// (3 integer bits incl. sign, FRAC_EST fraction bits).
module sd_digit_select
  import online_sd_pkg::*;
#(
  parameter int FRAC_EST = 2
) (
  input  logic signed [FRAC_EST+2:0] v_est,
  output logic        [1:0]          p
);

  localparam logic signed [FRAC_EST+2:0] HALF  = (FRAC_EST+3)'(1) << (FRAC_EST-1);
  localparam logic signed [FRAC_EST+2:0] NHALF = -HALF;

  always_comb begin
    p = SD_ZERO;
    if (v_est >= HALF)      p = SD_POS;
    else if (v_est < NHALF) p = SD_NEG;
  end

endmodule

// File: rtl/online_mult_hd_param.sv
// Radix-2 MSD-first online multiplier with NDIG-digit frames, online delay 3,
// joint X/Y handshake, output backpressure and an end-of-frame marker.
module online_mult_hd_param
  import online_sd_pkg::*;
#(
  parameter int NDIG     = 8,
  parameter int FRAC_EST = 2
) (
  input  logic       clk,
  input  logic       asyn_reset,
  input  logic [1:0] x_value,
  input  logic       data_x_vld,
  output logic       data_x_rdy,
  input  logic [1:0] y_value,
  input  logic       data_y_vld,
  output logic       data_y_rdy,
  output logic [1:0] p_value,
  output logic       data_out_vld,
  input  logic       data_out_rdy,
  output logic       data_out_last
);

  localparam int XW = NDIG + 2;           // operand registers, 1 integer bit
  localparam int WW = NDIG + 6;           // residual, 3 integer bits
  localparam int F  = NDIG + 3;           // residual fraction bits
  localparam int EW = FRAC_EST + 3;
  localparam int CW = $clog2(NDIG + DELTA);

  localparam logic [CW-1:0] CNT_LOAD_END = CW'(DELTA - 1);
  localparam logic [CW-1:0] CNT_RUN_END  = CW'(NDIG - 1);
  localparam logic [CW-1:0] CNT_LAST     = CW'(NDIG + DELTA - 1);
  localparam logic signed [WW-1:0] ONE   = WW'(1) << F;

  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic in_state, out_space, step, emit, frame_end;

  logic signed [XW-1:0] x_q, y_q, x_nxt, y_nxt, x_add, y_add, wgt;
  logic signed [WW-1:0] w_q, v, w_nxt, x_ext, y_ext, tx, ty, p_w;
  logic signed [EW-1:0] v_est;
  logic signed [1:0]    xd, yd, pd;
  logic        [1:0]    p_sel;

  // Control: handshake, step enable and next state.
  always_comb begin
    in_state   = (state == LOAD) || (state == RUN);
    out_space  = !data_out_vld || data_out_rdy;
    data_x_rdy = !asyn_reset && in_state && out_space && data_y_vld;
    data_y_rdy = !asyn_reset && in_state && out_space && data_x_vld;
    step       = !asyn_reset && out_space &&
                 ((in_state && data_x_vld && data_y_vld) || (state == FLUSH));
    emit       = step && (state != LOAD);
    frame_end  = step && (state == FLUSH) && (cnt == CNT_LAST);
    state_nxt  = state;
    case (state)
      LOAD:    if (step && cnt == CNT_LOAD_END) state_nxt = RUN;
      RUN:     if (step && cnt == CNT_RUN_END)  state_nxt = FLUSH;
      FLUSH:   if (frame_end)                   state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (asyn_reset) state <= LOAD;
    else            state <= state_nxt;
  end

  // Recurrence: Y is appended before use, X after (X term uses the old prefix).
  always_comb begin
    xd  = in_state ? sd_to_int(x_value) : 2'sd0;
    yd  = in_state ? sd_to_int(y_value) : 2'sd0;
    wgt = XW'(1) << (CW'(NDIG) - cnt);
    x_add = '0;
    y_add = '0;
    if (xd == 2'sd1)       x_add = wgt;
    else if (xd == -2'sd1) x_add = -wgt;
    if (yd == 2'sd1)       y_add = wgt;
    else if (yd == -2'sd1) y_add = -wgt;
    x_nxt = x_q + x_add;
    y_nxt = y_q + y_add;
    // Operand LSB is always zero, so the 2^-3 alignment is an exact >>> 1.
    y_ext = {{(WW-XW){y_nxt[XW-1]}}, y_nxt};
    x_ext = {{(WW-XW){x_q[XW-1]}}, x_q};
    tx = '0;
    ty = '0;
    if (xd == 2'sd1)       tx = y_ext >>> 1;
    else if (xd == -2'sd1) tx = -(y_ext >>> 1);
    if (yd == 2'sd1)       ty = x_ext >>> 1;
    else if (yd == -2'sd1) ty = -(x_ext >>> 1);
    v     = (w_q <<< 1) + tx + ty;
    v_est = v[WW-1 -: EW];
    // Initial delay steps only accumulate; no digit is retired.
    pd  = (state == LOAD) ? 2'sd0 : sd_to_int(p_sel);
    p_w = '0;
    if (pd == 2'sd1)       p_w = ONE;
    else if (pd == -2'sd1) p_w = -ONE;
    w_nxt = v - p_w;
  end

  sd_digit_select #(.FRAC_EST(FRAC_EST)) u_sel (
    .v_est (v_est),
    .p     (p_sel)
  );

  always_ff @(posedge clk) begin
    if (asyn_reset) begin
      x_q           <= '0;
      y_q           <= '0;
      w_q           <= '0;
      cnt           <= '0;
      p_value       <= SD_ZERO;
      data_out_vld  <= 1'b0;
      data_out_last <= 1'b0;
    end else begin
      if (frame_end) begin
        x_q <= '0;
        y_q <= '0;
        w_q <= '0;
        cnt <= '0;
      end else if (step) begin
        x_q <= x_nxt;
        y_q <= y_nxt;
        w_q <= w_nxt;
        cnt <= cnt + CW'(1);
      end
      if (emit) begin
        p_value       <= int_to_sd(pd);
        data_out_vld  <= 1'b1;
        data_out_last <= frame_end;
      end else if (data_out_vld && data_out_rdy) begin
        data_out_vld  <= 1'b0;
        data_out_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_online_mult_hd_param.sv
// Directed bench for online_mult_hd_param (NDIG=8 and NDIG=16 instances).
module tb_online_mult_hd_param;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] x8, y8, p8, x16, y16, p16;
  logic xv8, yv8, xr8, yr8, ov8, or8, ol8;
  logic xv16, yv16, xr16, yr16, ov16, or16, ol16;

  int tests = 0;
  int fails = 0;

  logic [1:0] qd8[$];
  logic [1:0] qd16[$];
  logic       ql8[$];
  logic       ql16[$];
  logic [15:0] saved;

  always #5 clk = ~clk;

  online_mult_hd_param #(.NDIG(8), .FRAC_EST(2)) dut8 (
    .clk(clk), .asyn_reset(rst),
    .x_value(x8), .data_x_vld(xv8), .data_x_rdy(xr8),
    .y_value(y8), .data_y_vld(yv8), .data_y_rdy(yr8),
    .p_value(p8), .data_out_vld(ov8), .data_out_rdy(or8), .data_out_last(ol8)
  );

  online_mult_hd_param #(.NDIG(16), .FRAC_EST(2)) dut16 (
    .clk(clk), .asyn_reset(rst),
    .x_value(x16), .data_x_vld(xv16), .data_x_rdy(xr16),
    .y_value(y16), .data_y_vld(yv16), .data_y_rdy(yr16),
    .p_value(p16), .data_out_vld(ov16), .data_out_rdy(or16), .data_out_last(ol16)
  );

  // Record every product digit that is actually transferred.
  always @(negedge clk) begin
    if (!rst) begin
      if (ov8 && or8) begin qd8.push_back(p8); ql8.push_back(ol8); end
      if (ov16 && or16) begin qd16.push_back(p16); ql16.push_back(ol16); end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic qclear();
    qd8.delete(); ql8.delete(); qd16.delete(); ql16.delete();
  endtask

  task automatic idle();
    xv8 = 1'b0; yv8 = 1'b0; xv16 = 1'b0; yv16 = 1'b0;
  endtask

  // Send the first n digit pairs (MSD first) of nd-digit operands; vld stays high.
  task automatic send(input int w, input logic [31:0] xv, input logic [31:0] yv,
                      input int n, input int nd, input bit chk_lat);
    int t;
    logic [1:0] xd, yd;
    for (int k = 0; k < n; k++) begin
      xd = xv[2*nd-1-2*k -: 2];
      yd = yv[2*nd-1-2*k -: 2];
      if (w == 0) begin x8 = xd; y8 = yd; xv8 = 1'b1; yv8 = 1'b1; end
      else        begin x16 = xd; y16 = yd; xv16 = 1'b1; yv16 = 1'b1; end
      t = 0;
      @(negedge clk);
      while (!(w == 0 ? xr8 : xr16) && t < 200) begin t++; @(negedge clk); end
      tests++;
      assert (t < 200) else begin
        fails++;
        $error("FAIL send_timeout observed=%0d cycles expected=<200", t);
      end
      if (t >= 200) return;
      @(posedge clk); #1;
      if (chk_lat) chk($sformatf("latency_pair%0d", k + 1), (w == 0) ? ov8 : ov16, k >= 3);
    end
  endtask

  task automatic wait_digits(input int w, input int n, input string tag);
    int t = 0;
    while (((w == 0) ? qd8.size() : qd16.size()) < n && t < 300) begin
      @(negedge clk); t++;
    end
    @(posedge clk); #1;
    chk({tag, "_ndig"}, (w == 0) ? qd8.size() : qd16.size(), n);
  endtask

  // Reconstruct the product value, check accuracy, legality and last marker.
  task automatic check_frame(input int w, input int first, input int nd,
                             input longint target, input string tag);
    longint s = 0;
    longint diff;
    logic [31:0] lm = '0;
    int bad = 0;
    logic [1:0] d;
    logic l;
    if (((w == 0) ? qd8.size() : qd16.size()) < first + nd) begin
      tests++; fails++;
      $error("FAIL %s_short observed=%0d digits expected=%0d", tag,
             (w == 0) ? qd8.size() : qd16.size(), first + nd);
      return;
    end
    for (int i = 0; i < nd; i++) begin
      d = (w == 0) ? qd8[first+i] : qd16[first+i];
      l = (w == 0) ? ql8[first+i] : ql16[first+i];
      if (d == 2'b01)      s += longint'(1) << (nd - 1 - i);
      else if (d == 2'b11) s -= longint'(1) << (nd - 1 - i);
      else if (d == 2'b10) bad++;
      lm[i] = l;
    end
    diff = (s << nd) - target;
    if (diff < 0) diff = -diff;
    tests++;
    assert (diff <= (longint'(1) << nd)) else begin
      fails++;
      $error("FAIL %s_value observed=%0d/2^%0d expected=%0d/2^%0d +-2^%0d",
             tag, s, nd, target, 2*nd, nd);
    end
    chk({tag, "_last"}, lm, 32'(1) << (nd - 1));
    chk({tag, "_illegal"}, bad, 0);
  endtask

  function automatic logic [15:0] pack8(input int first);
    logic [15:0] r;
    for (int i = 0; i < 8; i++)
      r[15-2*i -: 2] = (first + i < qd8.size()) ? qd8[first+i] : 2'b10;
    return r;
  endfunction

  task automatic stall_at_digit3();
    logic [3:0] snap;
    int t = 0;
    @(posedge clk); #1;
    while (!(qd8.size() == 2 && ov8) && t < 200) begin @(posedge clk); #1; t++; end
    chk("t4_reach_digit3", t < 200, 1'b1);
    or8 = 1'b0;
    snap = {p8, ov8, ol8};
    repeat (5) begin
      @(negedge clk);
      chk("t4_hold_out", {p8, ov8, ol8}, snap);
      chk("t4_no_rdy", {xr8, yr8}, 2'b00);
    end
    @(posedge clk); #1;
    or8 = 1'b1;
  endtask

  initial begin
    rst = 1'b1; or8 = 1'b1; or16 = 1'b1;
    x8 = '0; y8 = '0; x16 = '0; y16 = '0;
    idle();
    repeat (3) @(posedge clk);
    #1; xv8 = 1'b1; yv8 = 1'b1;
    @(negedge clk);
    chk("rst_vld", ov8, 1'b0);
    chk("rst_last", ol8, 1'b0);
    chk("rst_p", p8, 2'b00);
    chk("rst_rdy", {xr8, yr8}, 2'b00);
    chk("rst_vld16", ov16, 1'b0);
    idle();
    @(posedge clk); #1; rst = 1'b0;

    // 1: zero operands
    qclear();
    send(0, 32'h0000, 32'h0000, 8, 8, 1'b1); idle();
    wait_digits(0, 8, "t1");
    check_frame(0, 0, 8, 0, "t1");
    chk("t1_digits", pack8(0), 16'h0000);

    // 2: 1/2 * 1/2 and 1/2 * -1/2
    qclear();
    send(0, 32'h4000, 32'h4000, 8, 8, 1'b1); idle();
    wait_digits(0, 8, "t2a");
    check_frame(0, 0, 8, 16384, "t2a");
    qclear();
    send(0, 32'h4000, 32'hC000, 8, 8, 1'b1); idle();
    wait_digits(0, 8, "t2b");
    check_frame(0, 0, 8, -16384, "t2b");

    // 3: 255/256 squared, then 16-digit all-ones
    qclear();
    send(0, 32'h5555, 32'h5555, 8, 8, 1'b1); idle();
    wait_digits(0, 8, "t3");
    check_frame(0, 0, 8, 65025, "t3");
    saved = pack8(0);
    send(1, 32'h5555_5555, 32'h5555_5555, 16, 16, 1'b1); idle();
    wait_digits(1, 16, "t3w");
    check_frame(1, 0, 16, 64'd4294836225, "t3w");

    // 4: backpressure at digit 3
    qclear();
    fork
      send(0, 32'h5555, 32'h5555, 8, 8, 1'b0);
      stall_at_digit3();
    join
    idle();
    wait_digits(0, 8, "t4");
    check_frame(0, 0, 8, 65025, "t4");
    chk("t4_same_as_unstalled", pack8(0), saved);

    // 5: lone X valid never transfers; then back-to-back frames
    qclear();
    x8 = 2'b01; y8 = 2'b01; xv8 = 1'b1; yv8 = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("t5_xrdy_alone", xr8, 1'b0);
      chk("t5_no_out", ov8, 1'b0);
    end
    @(posedge clk); #1; idle();
    send(0, 32'h4000, 32'h4000, 8, 8, 1'b1);
    send(0, 32'h4000, 32'hC000, 8, 8, 1'b0);
    idle();
    wait_digits(0, 16, "t5");
    check_frame(0, 0, 8, 16384, "t5_f1");
    check_frame(0, 8, 8, -16384, "t5_f2");

    // 6: reset mid-frame, then a clean frame
    qclear();
    send(0, 32'h5555, 32'h5555, 6, 8, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rdy_in_reset", {xr8, yr8}, 2'b00);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    chk("t6_vld_after_rst", ov8, 1'b0);
    chk("t6_last_after_rst", ol8, 1'b0);
    chk("t6_p_after_rst", p8, 2'b00);
    @(posedge clk); #1; rst = 1'b0;
    qclear();
    send(0, 32'h4000, 32'h4000, 8, 8, 1'b1); idle();
    wait_digits(0, 8, "t6");
    check_frame(0, 0, 8, 16384, "t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
